invert_ctrl: RTL and testbench
==============================

INVERT_CTRL -- requirements
Module: invert_ctrl

Interface
REQ-001 SHALL have parameter COORD_W, default 12, meaning the width of the pixel x/y counters and window coordinates.
REQ-002 SHALL have parameter PERIOD_W, default 8, meaning the width of the blink period in frames.
REQ-003 SHALL have one clock and a synchronous, active-high reset: port clk, input, 1 bit, the pixel clock.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port vde, input, 1 bit, video data enable of the pixel stream.
REQ-006 SHALL have port vsync, input, 1 bit, active-high vertical sync.
REQ-007 SHALL have port cfg_valid, input, 1 bit, request to load a new configuration.
REQ-008 SHALL have port cfg_ready, output, 1 bit, meaning the pending slot is empty and cfg_valid will be accepted.
REQ-009 SHALL have port cfg_mode, input, 2 bits: 0 OFF, 1 FULL, 2 WINDOW, 3 BLINK.
REQ-010 SHALL have ports cfg_x0, cfg_x1, cfg_y0 and cfg_y1, inputs, COORD_W bits each, the inclusive window bounds.
REQ-011 SHALL have port cfg_period, input, PERIOD_W bits, the blink half-period in frames.
REQ-012 SHALL have port en, output, 1 bit, the invert enable for the RGB invert datapath.
REQ-013 SHALL have port frame_cnt, output, 16 bits, a free-running frame counter that wraps.

Function
REQ-014 SHALL detect rising edges of vsync and falling edges of vde from one-cycle-delayed copies of each signal.
REQ-015 SHALL clear x when vde is low, and SHALL increment x on every cycle with vde high; x is the column of the pixel sampled on that cycle.
REQ-016 SHALL increment y on each vde falling edge and SHALL clear y on each vsync rising edge; x and y saturate at all-ones and do not wrap.
REQ-017 SHALL use a 2-state FSM: WAIT_SYNC (en=0) -> RUN on the first vsync rising edge; RUN holds until reset.
REQ-018 SHALL accept a configuration when cfg_valid and cfg_ready are both 1, capturing all cfg_* fields into a pending register; cfg_ready then drops the next cycle.
REQ-019 SHALL copy the pending configuration into the active configuration on the next vsync rising edge and SHALL raise cfg_ready the following cycle.
REQ-020 SHALL apply a configuration accepted in the same cycle as a vsync rising edge at the following vsync edge, not the current one.
REQ-021 SHALL register en, asserting it one cycle after the pixel it applies to; the integrator delays the pixel bus by one register to match.
REQ-022 SHALL drive en=0 whenever the sampled vde=0 or the FSM is in WAIT_SYNC.
REQ-023 SHALL drive en=1 for every active pixel in FULL mode.
REQ-024 SHALL drive en=1 in WINDOW mode only when x0<=x<=x1 and y0<=y<=y1 (unsigned comparison); x0>x1 or y0>y1 gives an empty window.
REQ-025 SHALL in BLINK mode keep a frame count from 0 to P-1 and toggle a phase bit when the count wraps, where P=max(cfg_period,1); en equals phase on active pixels.
REQ-026 SHALL clear the blink counter and phase when a configuration is applied.
REQ-027 SHALL increment frame_cnt on every vsync rising edge in either FSM state, wrapping from 0xFFFF to 0.

Reset
REQ-028 SHALL on rst set: FSM=WAIT_SYNC, en=0, cfg_ready=1, frame_cnt=0, x=y=0, blink count=0, phase=0, active mode=OFF, pending slot empty, edge-detect registers=0.
REQ-029 SHALL let reset asserted mid-frame or with a configuration pending discard the pending configuration, with en low on the cycle after rst is sampled.

Structure
REQ-030 SHALL place the mode encodings (OFF/FULL/WINDOW/BLINK), the FSM state encodings and the default COORD_W in the shared package invert_pkg.
REQ-031 SHALL implement the x/y counters and edge detection in one sub-module, pixel_pos_counter; the configuration handshake, FSM and enable logic stay in invert_ctrl.

Verification (timing: 8 active pixels x 4 lines, 4-cycle blanking)
REQ-032 SHALL check: reset, then FULL loaded before the first vsync -> en=0 until the first vsync edge; en=0 throughout frame 1 (OFF still active); en=1 on all 32 pixels of frame 2, delayed 1 cycle.
REQ-033 SHALL check: WINDOW x0=2,x1=4,y0=1,y1=2 -> en=1 on exactly 6 pixels per frame, at (2..4, 1..2).
REQ-034 SHALL check: WINDOW x0=5,x1=3 -> en=0 for the whole frame.
REQ-035 SHALL check: BLINK period=2 -> en pattern over frames is 0,0,1,1,0,0; with period=0 it alternates every frame.
REQ-036 SHALL check: cfg_valid on the same cycle as a vsync edge -> cfg_ready=0 for one full frame and the new mode takes effect one frame later; a second cfg_valid while cfg_ready=0 is ignored.
REQ-037 SHALL check: rst pulsed mid-frame with a configuration pending -> en=0 the next cycle, cfg_ready=1, frame_cnt=0, the pending mode is never applied; 65536 vsyncs -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/invert_pkg.sv
// rtl/invert_pkg.sv - shared encodings and default widths for the invert controller
package invert_pkg;

    localparam int DEFAULT_COORD_W  = 12;
    localparam int DEFAULT_PERIOD_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_FULL   = 2'd1,
        MODE_WINDOW = 2'd2,
        MODE_BLINK  = 2'd3
    } inv_mode_e;

    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_RUN       = 1'b1
    } inv_state_e;

endpackage

// File: rtl/pixel_pos_counter.sv
// rtl/pixel_pos_counter.sv - pixel x/y position and vsync edge tracking for the video stream
module pixel_pos_counter
    import invert_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vde,
    input  logic               vsync,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               vsync_rise
);

    logic               vde_dly_q, vde_dly_d;
    logic               vsync_dly_q, vsync_dly_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               vde_fall;

    assign vsync_rise = vsync & ~vsync_dly_q;
    assign vde_fall   = ~vde & vde_dly_q;

    // x_q holds the column of the pixel presented on the current cycle
    always_comb begin
        vde_dly_d   = vde;
        vsync_dly_d = vsync;
        x_d         = '0;
        if (vde) begin
            x_d = (x_q == '1) ? x_q : x_q + COORD_W'(1);
        end
        y_d = y_q;
        if (vsync_rise) begin
            y_d = '0;
        end else if (vde_fall && (y_q != '1)) begin
            y_d = y_q + COORD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vde_dly_q   <= 1'b0;
            vsync_dly_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
        end else begin
            vde_dly_q   <= vde_dly_d;
            vsync_dly_q <= vsync_dly_d;
            x_q         <= x_d;
            y_q         <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/invert_ctrl.sv
// rtl/invert_ctrl.sv - frame-synchronous RGB invert enable with double-buffered configuration
module invert_ctrl
    import invert_pkg::*;
#(
    parameter int COORD_W  = DEFAULT_COORD_W,
    parameter int PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vde,
    input  logic                vsync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    input  logic [COORD_W-1:0]  cfg_x0,
    input  logic [COORD_W-1:0]  cfg_x1,
    input  logic [COORD_W-1:0]  cfg_y0,
    input  logic [COORD_W-1:0]  cfg_y1,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                en,
    output logic [15:0]         frame_cnt
);

    logic [COORD_W-1:0] pix_x, pix_y;
    logic               vsync_rise;

    pixel_pos_counter #(.COORD_W(COORD_W)) u_pos (
        .clk        (clk),
        .rst        (rst),
        .vde        (vde),
        .vsync      (vsync),
        .x          (pix_x),
        .y          (pix_y),
        .vsync_rise (vsync_rise)
    );

    inv_state_e          state_q, state_d;
    logic                pend_valid_q, pend_valid_d;
    inv_mode_e           pend_mode_q, pend_mode_d;
    logic [COORD_W-1:0]  pend_x0_q, pend_x0_d, pend_x1_q, pend_x1_d;
    logic [COORD_W-1:0]  pend_y0_q, pend_y0_d, pend_y1_q, pend_y1_d;
    logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
    inv_mode_e           act_mode_q, act_mode_d;
    logic [COORD_W-1:0]  act_x0_q, act_x0_d, act_x1_q, act_x1_d;
    logic [COORD_W-1:0]  act_y0_q, act_y0_d, act_y1_q, act_y1_d;
    logic [PERIOD_W-1:0] act_period_q, act_period_d;
    logic [PERIOD_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                en_q, en_d;

    logic [PERIOD_W-1:0] period_eff;
    logic                cfg_accept;
    logic                in_window;

    assign cfg_ready  = ~pend_valid_q;
    assign cfg_accept = cfg_valid & ~pend_valid_q;
    assign period_eff = (act_period_q == '0) ? PERIOD_W'(1) : act_period_q;
    assign in_window  = (pix_x >= act_x0_q) && (pix_x <= act_x1_q) &&
                        (pix_y >= act_y0_q) && (pix_y <= act_y1_q);

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_mode_d   = pend_mode_q;
        pend_x0_d     = pend_x0_q;
        pend_x1_d     = pend_x1_q;
        pend_y0_d     = pend_y0_q;
        pend_y1_d     = pend_y1_q;
        pend_period_d = pend_period_q;
        act_mode_d    = act_mode_q;
        act_x0_d      = act_x0_q;
        act_x1_d      = act_x1_q;
        act_y0_d      = act_y0_q;
        act_y1_d      = act_y1_q;
        act_period_d  = act_period_q;
        blink_cnt_d   = blink_cnt_q;
        phase_d       = phase_q;
        frame_cnt_d   = frame_cnt_q;
        en_d          = 1'b0;

        if (state_q == ST_WAIT_SYNC && vsync_rise) begin
            state_d = ST_RUN;
        end

        if (vsync_rise) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (pend_valid_q) begin
                act_mode_d   = pend_mode_q;
                act_x0_d     = pend_x0_q;
                act_x1_d     = pend_x1_q;
                act_y0_d     = pend_y0_q;
                act_y1_d     = pend_y1_q;
                act_period_d = pend_period_q;
                pend_valid_d = 1'b0;
                blink_cnt_d  = '0;
                phase_d      = 1'b0;
            end else if (blink_cnt_q >= period_eff - PERIOD_W'(1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + PERIOD_W'(1);
            end
        end

        // The slot is only free when nothing is pending, so an accept never collides with an apply
        if (cfg_accept) begin
            pend_valid_d  = 1'b1;
            pend_mode_d   = inv_mode_e'(cfg_mode);
            pend_x0_d     = cfg_x0;
            pend_x1_d     = cfg_x1;
            pend_y0_d     = cfg_y0;
            pend_y1_d     = cfg_y1;
            pend_period_d = cfg_period;
        end

        if (vde && state_q == ST_RUN) begin
            case (act_mode_q)
                MODE_FULL:   en_d = 1'b1;
                MODE_WINDOW: en_d = in_window;
                MODE_BLINK:  en_d = phase_q;
                default:     en_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_WAIT_SYNC;
            pend_valid_q  <= 1'b0;
            pend_mode_q   <= MODE_OFF;
            pend_x0_q     <= '0;
            pend_x1_q     <= '0;
            pend_y0_q     <= '0;
            pend_y1_q     <= '0;
            pend_period_q <= '0;
            act_mode_q    <= MODE_OFF;
            act_x0_q      <= '0;
            act_x1_q      <= '0;
            act_y0_q      <= '0;
            act_y1_q      <= '0;
            act_period_q  <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            frame_cnt_q   <= '0;
            en_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_mode_q   <= pend_mode_d;
            pend_x0_q     <= pend_x0_d;
            pend_x1_q     <= pend_x1_d;
            pend_y0_q     <= pend_y0_d;
            pend_y1_q     <= pend_y1_d;
            pend_period_q <= pend_period_d;
            act_mode_q    <= act_mode_d;
            act_x0_q      <= act_x0_d;
            act_x1_q      <= act_x1_d;
            act_y0_q      <= act_y0_d;
            act_y1_q      <= act_y1_d;
            act_period_q  <= act_period_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            frame_cnt_q   <= frame_cnt_d;
            en_q          <= en_d;
        end
    end

    assign en        = en_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_invert_ctrl.sv
// tb/tb_invert_ctrl.sv - randomized and directed bench for invert_ctrl against a frame-level model
module tb_invert_ctrl;

    logic        clk = 1'b0;
    logic        rst, vde, vsync, cfg_valid, cfg_ready, en;
    logic [1:0]  cfg_mode;
    logic [11:0] cfg_x0, cfg_x1, cfg_y0, cfg_y1;
    logic [7:0]  cfg_period;
    logic [15:0] frame_cnt;

    invert_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vde        (vde),
        .vsync      (vsync),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_x0     (cfg_x0),
        .cfg_x1     (cfg_x1),
        .cfg_y0     (cfg_y0),
        .cfg_y1     (cfg_y1),
        .cfg_period (cfg_period),
        .en         (en),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // frame-level reference state
    bit          m_run, m_pend, m_vs_prev, m_phase;
    int          m_bcnt;
    logic [15:0] m_frame;
    int          a_mode, a_x0, a_x1, a_y0, a_y1, a_per;
    int          p_mode, p_x0, p_x1, p_y0, p_y1, p_per;
    int          n_mode, n_x0, n_x1, n_y0, n_y1, n_per;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_vs_prev = 0; m_phase = 0; m_bcnt = 0; m_frame = '0;
        a_mode = 0; a_x0 = 0; a_x1 = 0; a_y0 = 0; a_y1 = 0; a_per = 0;
    endtask

    task automatic set_cfg(input int md, input int x0, input int x1, input int y0, input int y1, input int per);
        n_mode = md; n_x0 = x0; n_x1 = x1; n_y0 = y0; n_y1 = y1; n_per = per;
        cfg_mode = 2'(md); cfg_x0 = 12'(x0); cfg_x1 = 12'(x1);
        cfg_y0 = 12'(y0); cfg_y1 = 12'(y1); cfg_period = 8'(per);
    endtask

    function automatic bit pix_on(input int px, input int py);
        case (a_mode)
            1:       return 1'b1;
            2:       return (px >= a_x0) && (px <= a_x1) && (py >= a_y0) && (py <= a_y1);
            3:       return m_phase;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_cycle(input bit vde_i, input bit vs_i, input int px, input int py,
                            input bit req, input bit rst_i, output bit en_o);
        bit exp_en, rise, acc;
        int per_eff;
        rst = rst_i; vde = vde_i; vsync = vs_i; cfg_valid = req;
        rise    = vs_i && !m_vs_prev;
        exp_en  = !rst_i && vde_i && m_run && pix_on(px, py);
        acc     = req && !m_pend;
        if (rst_i) begin
            model_reset();
        end else begin
            if (rise) begin
                if (m_pend) begin
                    a_mode = p_mode; a_x0 = p_x0; a_x1 = p_x1; a_y0 = p_y0; a_y1 = p_y1; a_per = p_per;
                    m_pend = 0; m_bcnt = 0; m_phase = 0;
                end else begin
                    per_eff = (a_per == 0) ? 1 : a_per;
                    m_bcnt++;
                    if (m_bcnt >= per_eff) begin
                        m_bcnt  = 0;
                        m_phase = !m_phase;
                    end
                end
                m_frame++;
                m_run = 1;
            end
            if (acc) begin
                m_pend = 1;
                p_mode = n_mode; p_x0 = n_x0; p_x1 = n_x1; p_y0 = n_y0; p_y1 = n_y1; p_per = n_per;
            end
            m_vs_prev = vs_i;
        end
        @(posedge clk);
        #1;
        check_eq("en", en, exp_en);
        check_eq("cfg_ready", cfg_ready, !m_pend);
        check_eq("frame_cnt", frame_cnt, m_frame);
        en_o = en;
        cfg_valid = 1'b0;
        rst = 1'b0;
    endtask

    // 4 lines of 8 active + 4 blank pixels, then 4-cycle vblank with vsync rising at cycle 48
    task automatic run_frame(input int cfg_at, input int rst_at, output int cnt);
        int c;
        bit e;
        c = 0; cnt = 0;
        for (int ln = 0; ln < 4; ln++) begin
            for (int px = 0; px < 8; px++) begin
                do_cycle(1'b1, 1'b0, px, ln, c == cfg_at, c == rst_at, e); cnt += int'(e); c++;
            end
            for (int b = 0; b < 4; b++) begin
                do_cycle(1'b0, 1'b0, 0, 0, c == cfg_at, c == rst_at, e); cnt += int'(e); c++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            do_cycle(1'b0, b < 2, 0, 0, c == cfg_at, c == rst_at, e); cnt += int'(e); c++;
        end
    endtask

    initial begin
        int cnt;
        bit e;
        int blink2 [6];
        int blink0 [4];
        blink2 = '{0, 0, 32, 32, 0, 0};
        blink0 = '{0, 32, 0, 32};

        rst = 1'b1; vde = 1'b0; vsync = 1'b0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        model_reset();
        do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, e);
        do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, e);

        set_cfg(1, 0, 0, 0, 0, 0);
        run_frame(0, -1, cnt);  check_eq("full_frame1", cnt, 0);
        run_frame(-1, -1, cnt); check_eq("full_frame2", cnt, 32);

        set_cfg(2, 2, 4, 1, 2, 0);
        run_frame(10, -1, cnt); check_eq("win_pre", cnt, 32);
        run_frame(-1, -1, cnt); check_eq("win_a", cnt, 6);
        run_frame(-1, -1, cnt); check_eq("win_b", cnt, 6);

        set_cfg(2, 5, 3, 0, 3, 0);
        run_frame(0, -1, cnt);  check_eq("empty_pre", cnt, 6);
        run_frame(-1, -1, cnt); check_eq("empty_win", cnt, 0);

        set_cfg(3, 0, 0, 0, 0, 2);
        run_frame(0, -1, cnt);  check_eq("blink_pre", cnt, 0);
        for (int f = 0; f < 6; f++) begin
            run_frame(-1, -1, cnt); check_eq("blink_p2", cnt, blink2[f]);
        end
        set_cfg(3, 0, 0, 0, 0, 0);
        run_frame(0, -1, cnt);
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, -1, cnt); check_eq("blink_p0", cnt, blink0[f]);
        end

        set_cfg(1, 0, 0, 0, 0, 0);
        run_frame(0, -1, cnt);
        run_frame(-1, -1, cnt); check_eq("full_again", cnt, 32);
        set_cfg(2, 0, 7, 0, 0, 0);
        run_frame(48, -1, cnt); check_eq("edge_cfg_frame", cnt, 32);
        check_eq("edge_cfg_ready", cfg_ready, 0);
        set_cfg(0, 0, 0, 0, 0, 0);
        run_frame(20, -1, cnt); check_eq("edge_cfg_old", cnt, 32);
        run_frame(-1, -1, cnt); check_eq("edge_cfg_new", cnt, 8);
        run_frame(-1, -1, cnt); check_eq("second_cfg_ignored", cnt, 8);

        set_cfg(1, 0, 0, 0, 0, 0);
        run_frame(1, 3, cnt);   check_eq("rst_mid_frame", cnt, 3);
        check_eq("rst_frame_cnt", frame_cnt, 1);
        run_frame(-1, -1, cnt); check_eq("pend_discarded", cnt, 0);

        for (int f = 0; f < 40; f++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
            run_frame(($urandom_range(0, 1) == 1) ? $urandom_range(0, 51) : -1,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 51) : -1, cnt);
        end

        do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b1, e);
        check_eq("wrap_start", frame_cnt, 0);
        for (int i = 0; i < 65536; i++) begin
            do_cycle(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, e);
            do_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, e);
        end
        check_eq("frame_wrap", frame_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
